// File: rtl/mem_boot_ctrl_pkg.sv
// Shared types for the boot-time RAM port controller.
package mem_ctrl_pkg;
  typedef enum logic [1:0] {CLEAR, LOAD, RUN} boot_state_t;
endpackage

// File: rtl/mem_boot_ctrl_if.sv
// Loader, CPU and RAM port bundle around mem_boot_ctrl; slave = controller side.
interface mem_boot_ctrl_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  start_boot;
  logic                  ld_valid;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  ld_last;
  logic                  ld_ready;
  logic                  cpu_wr_en;
  logic [ADDR_WIDTH-1:0] cpu_wr_addr;
  logic [DATA_WIDTH-1:0] cpu_wr_data;
  logic [ADDR_WIDTH-1:0] cpu_rd_addr;
  logic [DATA_WIDTH-1:0] cpu_rd_data;
  logic                  mem_wr_en;
  logic [ADDR_WIDTH-1:0] mem_wr_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  cpu_run;
  logic [ADDR_WIDTH:0]   load_count;
  logic                  load_err;

  modport slave (
    input  start_boot, ld_valid, ld_data, ld_last,
    input  cpu_wr_en, cpu_wr_addr, cpu_wr_data, cpu_rd_addr, mem_rd_data,
    output ld_ready, cpu_rd_data, mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_addr,
    output cpu_run, load_count, load_err
  );

  modport master (
    output start_boot, ld_valid, ld_data, ld_last,
    output cpu_wr_en, cpu_wr_addr, cpu_wr_data, cpu_rd_addr, mem_rd_data,
    input  ld_ready, cpu_rd_data, mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_addr,
    input  cpu_run, load_count, load_err
  );
endinterface

// File: rtl/mem_boot_ctrl.sv
// Sequences the CPU RAM ports through zero-fill, program load and run;
// the CPU only sees the RAM once the load has finished.
module mem_boot_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter bit CLEAR_EN   = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  mem_boot_ctrl_if.slave   bus
);
  localparam logic [ADDR_WIDTH-1:0] PTR_MAX    = '1;
  localparam boot_state_t           BOOT_ENTRY = CLEAR_EN ? CLEAR : LOAD;

  boot_state_t           state, state_nx;
  logic [ADDR_WIDTH-1:0] ptr, ptr_nx;
  logic                  accept;
  logic                  ld_ready;
  logic                  mem_wr_en;
  logic [ADDR_WIDTH-1:0] mem_wr_addr, mem_rd_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data, cpu_rd_data;
  logic                  cpu_run;
  logic [ADDR_WIDTH:0]   load_count;
  logic                  load_err;

  always_comb begin
    state_nx    = state;
    ptr_nx      = ptr;
    accept      = 1'b0;
    ld_ready    = 1'b0;
    mem_wr_en   = 1'b0;
    mem_wr_addr = ptr;
    mem_wr_data = '0;
    mem_rd_addr = ptr;
    cpu_rd_data = '0;
    case (state)
      CLEAR: begin
        mem_wr_en = 1'b1;
        ptr_nx    = ptr + 1'b1;   // wraps to 0 on the way into LOAD
        if (ptr == PTR_MAX) state_nx = LOAD;
      end
      LOAD: begin
        ld_ready = 1'b1;
        accept   = bus.ld_valid;
        if (accept) begin
          mem_wr_en   = 1'b1;
          mem_wr_data = bus.ld_data;
          ptr_nx      = ptr + 1'b1;
          if (bus.ld_last || ptr == PTR_MAX) state_nx = RUN;
        end
      end
      RUN: begin
        mem_wr_en   = bus.cpu_wr_en;
        mem_wr_addr = bus.cpu_wr_addr;
        mem_wr_data = bus.cpu_wr_data;
        mem_rd_addr = bus.cpu_rd_addr;
        cpu_rd_data = bus.mem_rd_data;
        if (bus.start_boot) begin
          state_nx = BOOT_ENTRY;
          ptr_nx   = '0;
        end
      end
      default: begin
        state_nx = BOOT_ENTRY;
        ptr_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= BOOT_ENTRY;
      ptr        <= '0;
      cpu_run    <= 1'b0;
      load_count <= '0;
      load_err   <= 1'b0;
    end else begin
      state   <= state_nx;
      ptr     <= ptr_nx;
      cpu_run <= (state_nx == RUN);
      if (state_nx == LOAD && state != LOAD) begin
        load_count <= '0;
        load_err   <= 1'b0;
      end else if (accept) begin
        load_count <= load_count + 1'b1;
        // RAM filled without an end marker: program was truncated
        if (ptr == PTR_MAX && !bus.ld_last) load_err <= 1'b1;
      end
    end
  end

  assign bus.ld_ready    = ld_ready;
  assign bus.mem_wr_en   = mem_wr_en;
  assign bus.mem_wr_addr = mem_wr_addr;
  assign bus.mem_wr_data = mem_wr_data;
  assign bus.mem_rd_addr = mem_rd_addr;
  assign bus.cpu_rd_data = cpu_rd_data;
  assign bus.cpu_run     = cpu_run;
  assign bus.load_count  = load_count;
  assign bus.load_err    = load_err;
endmodule

// File: doc/mem_boot_ctrl.md
Name: mem_boot_ctrl

Overview:
- Owns the CPU's RAM port group (one async-read port, one sync-write port) and sequences it through boot.
- After reset it zero-fills RAM, then loads a program from a byte-stream loader via valid/ready, then hands both ports to the CPU and releases it.
- Sits between the CPU core, the loader (UART/switch front-end) and the 2**ADDR_WIDTH x DATA_WIDTH RAM.

Parameters:
ADDR_WIDTH, 4, RAM address width; DEPTH = 2**ADDR_WIDTH
DATA_WIDTH, 8, RAM word width
CLEAR_EN, 1, 1 = run the zero-fill phase before load; 0 = skip straight to load

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous active-high reset
start_boot  in  1  pulse in RUN re-enters boot; ignored in other states
ld_valid  in  1  loader byte valid
ld_data  in  DATA_WIDTH  loader byte
ld_last  in  1  marks final program byte, qualified by ld_valid
ld_ready  out  1  controller accepts loader byte this cycle
cpu_wr_en  in  1  CPU write strobe
cpu_wr_addr  in  ADDR_WIDTH  CPU write address
cpu_wr_data  in  DATA_WIDTH  CPU write data
cpu_rd_addr  in  ADDR_WIDTH  CPU read address
cpu_rd_data  out  DATA_WIDTH  CPU read data
mem_wr_en  out  1  to RAM write enable
mem_wr_addr  out  ADDR_WIDTH  to RAM write address
mem_wr_data  out  DATA_WIDTH  to RAM write data
mem_rd_addr  out  ADDR_WIDTH  to RAM read address
mem_rd_data  in  DATA_WIDTH  from RAM read data (combinational)
cpu_run  out  1  CPU may execute; low holds the CPU in halt
load_count  out  ADDR_WIDTH+1  bytes accepted in the last or current load
load_err  out  1  sticky: load ended by filling RAM without ld_last

Behaviour:
- Interface: one clock, clk. reset is synchronous, active-high, and overrides everything, including mid-CLEAR, mid-LOAD and RUN.
- On reset: state = CLEAR (LOAD if CLEAR_EN=0), ptr = 0, load_count = 0, load_err = 0, cpu_run = 0.
- States are CLEAR, LOAD and RUN. ptr is an ADDR_WIDTH-bit address counter.
- CLEAR:
  - mem_wr_en = 1, mem_wr_addr = ptr, mem_wr_data = 0, ld_ready = 0.
  - ptr increments each cycle.
  - When ptr = DEPTH-1, the next state is LOAD and ptr wraps to 0.
  - Duration is exactly DEPTH cycles.
- LOAD:
  - ld_ready = 1. A byte is accepted when ld_valid & ld_ready.
  - Accept drives mem_wr_en = 1, mem_wr_addr = ptr, mem_wr_data = ld_data (same-cycle write). It also increments ptr and load_count.
  - No accept means mem_wr_en = 0.
  - Entry to LOAD clears load_count and load_err.
  - Accept with ld_last = 1 moves to RUN next cycle.
  - Accept at ptr = DEPTH-1 with ld_last = 0 moves to RUN and sets load_err (truncation). With ld_last = 1 there, load_err stays 0.
  - ld_last without ld_valid is ignored.
- RUN:
  - cpu_run = 1, ld_ready = 0.
  - Write path: mem_wr_* = cpu_wr_* (pass-through). Read path: mem_rd_addr = cpu_rd_addr, cpu_rd_data = mem_rd_data.
  - start_boot = 1 moves to CLEAR (or LOAD if CLEAR_EN=0) next cycle, with ptr = 0 and cpu_run low that cycle.
- Outside RUN: cpu_run = 0, cpu_rd_data = 0, cpu_wr_en ignored (never reaches RAM), mem_rd_addr = ptr.
- cpu_run, load_count and load_err are registered. ld_ready and the mem_* outputs are combinational from state/ptr/inputs.
- Post-reset latency: first RUN cycle is cycle DEPTH+N+1 after reset release (N bytes, valid every cycle, CLEAR_EN=1).
- Simultaneous events:
  - start_boot with cpu_wr_en in the last RUN cycle: the CPU write still commits.
  - start_boot outside RUN has no effect.

Decomposition:
- Package mem_ctrl_pkg: boot_state_t enum {CLEAR, LOAD, RUN}.
- No sub-module; ptr counter and muxing are inline. Integration pairs this block with the existing RAM module.

Test Plan:
- Reset, DEPTH=16, CLEAR_EN=1, RAM pre-seeded 0xFF -> 16 cycles of mem_wr_en=1, data 0x00, addrs 0..15; ld_ready rises cycle 17; all RAM = 0x00.
- Load 3 bytes 0xA1,0xB2,0xC3, last on 0xC3, valid every cycle -> RAM[0..2] = A1,B2,C3, RAM[3..15] = 00; load_count = 3; cpu_run = 1 the cycle after 0xC3 accepted; load_err = 0.
- Gapped loader (valid 1,0,0,1,1) -> only valid cycles write, mem_wr_en = 0 in gaps, load_count = 3.
- 16 bytes 0x10..0x1F, no ld_last -> RUN after byte 16, load_err = 1, load_count = 16; same with ld_last on byte 16 -> load_err = 0.
- In RUN: CPU writes 0x5A to addr 7, reads addr 7 -> cpu_rd_data = 0x5A; in LOAD, cpu_wr_en = 1 to addr 7 -> RAM unchanged, cpu_rd_data = 0.
- start_boot in RUN -> cpu_run = 0 next cycle, clear restarts at addr 0. Reset asserted mid-LOAD (after 2 bytes) -> CLEAR, load_count = 0, cpu_run = 0.
